// File: rtl/rr_mux_pipe_pkg.sv
// rr_mux_pipe_pkg: shared mode encoding and default sizes for the registered round-robin word selector.
package rr_mux_pipe_pkg;
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;
  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_CHANNELS = 32;
endpackage

// File: rtl/rr_mux_pipe_pick.sv
// rr_pick: combinational round-robin picker; first requester at or after ptr, wrapping cyclically.
module rr_pick #(
  parameter  int CHANNELS = 32,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [SEL_W-1:0]    i_ptr,
  output logic                o_grant_valid,
  output logic [SEL_W-1:0]    o_grant_idx
);
  localparam logic [SEL_W:0] CH = (SEL_W+1)'(CHANNELS);
  logic [2*CHANNELS-1:0] w_req2;
  logic [SEL_W:0]        w_pos;
  logic                  w_hit;
  assign w_req2 = {i_req, i_req};
  // Upper copy supplies the wrapped-around requesters below ptr; scanning down keeps the lowest hit.
  always_comb begin
    w_hit = 1'b0;
    w_pos = '0;
    for (int i = 2*CHANNELS-1; i >= 0; i--)
      if (w_req2[i] && i >= int'(i_ptr)) begin
        w_hit = 1'b1;
        w_pos = (SEL_W+1)'(i);
      end
  end
  assign o_grant_valid = w_hit;
  assign o_grant_idx   = SEL_W'(w_pos >= CH ? w_pos - CH : w_pos);
endmodule

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: N:1 word selector (direct or round-robin) with a one-entry valid/ready output register.
module rr_mux_pipe import rr_mux_pipe_pkg::*; #(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_select,
  input  logic [CHANNELS-1:0]       i_in_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  output logic [CHANNELS-1:0]       o_in_ready,
  output logic                      o_out_valid,
  output logic [WIDTH-1:0]          o_out_data,
  output logic [SEL_W-1:0]          o_out_chan,
  input  logic                      i_out_ready
);
  logic                  r_valid;
  logic [WIDTH-1:0]      r_data;
  logic [SEL_W-1:0]      r_chan;
  logic [SEL_W-1:0]      r_ptr;
  logic                  w_load_en;
  logic                  w_grant;
  logic                  w_xfer;
  logic                  w_pick_valid;
  logic [SEL_W-1:0]      w_pick_idx;
  logic [SEL_W-1:0]      w_g;
  logic [2**SEL_W-1:0]   w_vpad;
  logic [WIDTH-1:0]      w_word;
  rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .i_req         (i_in_valid),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_pick_valid),
    .o_grant_idx   (w_pick_idx)
  );
  // Padding lets an out-of-range direct select index safely; the range test rejects it.
  assign w_vpad    = (2**SEL_W)'(i_in_valid);
  assign w_load_en = !r_valid || i_out_ready;
  assign w_g       = (i_mode == MODE_RR) ? w_pick_idx : i_select;
  assign w_grant   = !i_reset && ((i_mode == MODE_RR) ? w_pick_valid
                                  : (int'(i_select) < CHANNELS && w_vpad[i_select]));
  assign w_xfer    = w_load_en && w_grant;
  assign w_word    = i_in_data[w_g*WIDTH +: WIDTH];
  assign o_in_ready = w_xfer ? CHANNELS'(1) << w_g : '0;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_data <= w_word;
        r_chan <= w_g;
        if (i_mode == MODE_RR) r_ptr <= (w_g == SEL_W'(CHANNELS-1)) ? '0 : w_g + 1'b1;
      end
    end
  end
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_chan  = r_chan;
endmodule

// File: tb/tb_rr_mux_pipe.sv
// tb_rr_mux_pipe: directed and random checks of 32- and 5-channel instances against a cyclic-search model.
module tb_rr_mux_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic         rst, mode, out_ready;
  logic [4:0]   sel;
  logic [2:0]   sel_b;
  logic [31:0]  vld;
  logic [31:0]  words [32];
  logic [1023:0] data_a;
  logic [159:0]  data_b;
  logic [31:0]  rdy_a, od_a, od_b;
  logic [4:0]   rdy_b, oc_a;
  logic [2:0]   oc_b;
  logic         ov_a, ov_b;
  int tests = 0, fails = 0;
  bit          mv [2];
  logic [31:0] md [2];
  int          mc [2], mp [2];

  always_comb begin
    for (int k = 0; k < 32; k++) data_a[k*32 +: 32] = words[k];
    for (int k = 0; k < 5; k++)  data_b[k*32 +: 32] = words[k];
  end

  rr_mux_pipe #(.WIDTH(32), .CHANNELS(32)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_mode(mode), .i_select(sel), .i_in_valid(vld),
    .i_in_data(data_a), .o_in_ready(rdy_a), .o_out_valid(ov_a), .o_out_data(od_a),
    .o_out_chan(oc_a), .i_out_ready(out_ready));
  rr_mux_pipe #(.WIDTH(32), .CHANNELS(5)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_mode(mode), .i_select(sel_b), .i_in_valid(vld[4:0]),
    .i_in_data(data_b), .o_in_ready(rdy_b), .o_out_valid(ov_b), .o_out_data(od_b),
    .o_out_chan(oc_b), .i_out_ready(out_ready));

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant by rule: direct = select if in range and valid; RR = first valid in cyclic order from ptr.
  function automatic void pick(int n, bit m, int s, logic [31:0] v, int p, output bit ok, output int g);
    ok = 0;
    g = s;
    if (!m) ok = (s < n) && v[s];
    else
      for (int k = 0; k < n; k++)
        if (!ok && v[(p + k) % n]) begin
          ok = 1;
          g = (p + k) % n;
        end
  endfunction

  task automatic step();
    bit ok [2];
    int g [2];
    bit le [2];
    logic [31:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      pick(d ? 5 : 32, mode, d ? int'(sel_b) : int'(sel), vld, mp[d], ok[d], g[d]);
      le[d] = !mv[d] || out_ready;
      er = (!rst && le[d] && ok[d]) ? 32'd1 << g[d] : 32'd0;
      if (d == 0) chk("ready_a", 64'(rdy_a), 64'(er));
      else        chk("ready_b", 64'(rdy_b), 64'(er));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mv[d] = 0; md[d] = 0; mc[d] = 0; mp[d] = 0;
      end else if (le[d]) begin
        mv[d] = ok[d];
        if (ok[d]) begin
          md[d] = words[g[d]];
          mc[d] = g[d];
          if (mode) mp[d] = (g[d] + 1) % (d ? 5 : 32);
        end
      end
    end
    #1;
    chk("valid_a", 64'(ov_a), 64'(mv[0]));
    chk("data_a",  64'(od_a), 64'(md[0]));
    chk("chan_a",  64'(oc_a), 64'(mc[0]));
    chk("valid_b", 64'(ov_b), 64'(mv[1]));
    chk("data_b",  64'(od_b), 64'(md[1]));
    chk("chan_b",  64'(oc_b), 64'(mc[1]));
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] seq_a [$];
    rst = 1; mode = 0; out_ready = 1; sel = 0; sel_b = 0; vld = 0;
    for (int k = 0; k < 32; k++) words[k] = 32'h1000_0000 + k;
    for (int d = 0; d < 2; d++) begin mv[d] = 0; md[d] = 0; mc[d] = 0; mp[d] = 0; end
    @(negedge clk);
    step();
    step();
    chk("reset_valid", 64'(ov_a), 64'd0);
    chk("reset_data",  64'(od_a), 64'd0);
    // Direct select 5 on the wide instance; select 6 is out of range for the 5-channel one.
    rst = 0; vld = '1; sel = 5; sel_b = 6;
    #1 chk("direct_ready_const", 64'(rdy_a), 64'h20);
    chk("direct_ready_b_none", 64'(rdy_b), 64'd0);
    step();
    chk("direct_data_const", 64'(od_a), 64'h1000_0005);
    chk("direct_chan_const", 64'(oc_a), 64'd5);
    vld[5] = 0;
    step();
    chk("nogrant_valid", 64'(ov_a), 64'd0);
    chk("nogrant_hold",  64'(od_a), 64'h1000_0005);
    // Round-robin over all channels from a fresh pointer.
    rst = 1; step(); rst = 0;
    mode = 1; vld = '1;
    for (int i = 0; i < 34; i++) begin
      step();
      seq_a.push_back(oc_a);
    end
    for (int i = 0; i < 34; i++) chk("rr_seq", 64'(seq_a[i]), 64'(i % 32));
    // Sparse requesters with wrap from ptr=31 back to 3.
    rst = 1; step(); rst = 0;
    vld = (32'd1 << 3) | (32'd1 << 17) | (32'd1 << 30);
    for (int i = 0; i < 4; i++) step();
    chk("rr_sparse_wrap", 64'(oc_a), 64'd3);
    // Backpressure with changing data, then release.
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 32; k++) words[k] = $urandom;
      step();
    end
    out_ready = 1;
    step();
    // Reset while holding a word.
    out_ready = 0; step();
    rst = 1; step();
    chk("reset_mid_valid", 64'(ov_b), 64'd0);
    chk("reset_mid_data",  64'(od_b), 64'd0);
    rst = 0; out_ready = 1;
    for (int i = 0; i < 400; i++) begin
      mode = 1'($urandom);
      sel = 5'($urandom);
      sel_b = 3'($urandom);
      vld = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      for (int k = 0; k < 32; k++) words[k] = $urandom;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_mux_pipe.md
Name: rr_mux_pipe

Overview:
Parametrised, registered N:1 word selector, successor to the fixed 32-way combinational word mux. Selects one of CHANNELS input words by an explicit select (direct mode) or by round-robin arbitration among valid requesters (RR mode). Delivers the result through a one-entry output register with valid/ready handshake. Used wherever several producers share one 32-bit consumer path (register read fan-in, sprite/score sources feeding the VGA/scoreboard logic).

Parameters:
WIDTH, 32, data word width in bits (1..64)
CHANNELS, 32, number of input channels (2..32)
SEL_W, $clog2(CHANNELS), derived localparam; select and channel-index width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = direct select, 1 = round-robin
select  input  SEL_W  channel index used in direct mode
in_valid  input  CHANNELS  per-channel word-available flag
in_data  input  CHANNELS*WIDTH  flattened words; channel k at [k*WIDTH +: WIDTH]
in_ready  output  CHANNELS  one-hot (or zero) accept strobe per channel, combinational
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered selected word
out_chan  output  SEL_W  channel index that produced out_data
out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset (reset=1 at clock edge): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0; in_ready forced to 0 while reset is high. Reset mid-transfer discards the held word.
- load_en = !out_valid || out_ready (register empty or being drained this cycle).
- Grant, direct mode: g = select; grant exists iff select < CHANNELS and in_valid[select]=1. select >= CHANNELS -> no grant, in_ready all 0.
- Grant, RR mode: g = first k in cyclic order ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 with in_valid[k]=1; no grant if in_valid is all 0. select ignored.
- in_ready[g] = load_en && grant; all other bits 0. At most one bit set.
- Transfer on edge when in_ready[g]=1: out_data<=in_data[g], out_chan<=g, out_valid<=1. In RR mode also ptr<=(g==CHANNELS-1)?0:g+1. Direct-mode transfers leave ptr unchanged.
- If load_en=1 and no grant: out_valid<=0; out_data/out_chan hold previous values.
- If out_valid=1 and out_ready=0: out_valid, out_data, out_chan held stable; no input accepted.
- Simultaneous drain and load (out_valid=1, out_ready=1, grant): new word replaces old in the same edge; sustained throughput of 1 word/cycle.
- Latency: input word visible on out_data exactly 1 cycle after its accept cycle.
- Mode change: takes effect in the cycle mode changes (grant logic is combinational on mode); ptr is preserved across mode changes.
- ptr never reaches CHANNELS; wrap from CHANNELS-1 to 0 is explicit (CHANNELS need not be a power of two).

Decomposition:
- Shared package/include: MODE_DIRECT=1'b0, MODE_RR=1'b1 constants; default WIDTH=32.
- One sub-module: rr_pick — combinational; inputs req[CHANNELS], ptr[SEL_W]; outputs grant_valid, grant_idx. Implemented as double-width request vector masked by ptr, priority-encoded, index reduced modulo CHANNELS. Top level holds the output register, ptr register and handshake logic.

Test Plan:
- Reset, then direct mode, select=5, in_valid=all 1s, in_data[k]=0x1000_0000+k, out_ready=1 -> in_ready=0x0000_0020; next cycle out_valid=1, out_data=0x1000_0005, out_chan=5.
- Direct mode, select=5, in_valid[5]=0 -> in_ready=0, out_valid falls to 0 next cycle, out_data holds 0x1000_0005.
- RR mode, in_valid=all 1s, out_ready=1 for 34 cycles from reset -> out_chan sequence 0,1,...,31,0,1; one word per cycle, no gaps.
- RR mode, in_valid bits {3,17,30} only, ptr starts at 0 -> grants 3,17,30,3; with ptr=31 after a grant of 30, next grant is 3 (wrap).
- Backpressure: out_valid=1, out_ready=0 for 4 cycles with changing in_data -> in_ready=0, out_data/out_chan stable; on out_ready=1 the next word loads same edge.
- CHANNELS=5 instance, RR mode, all valid -> out_chan 0,1,2,3,4,0; direct select=6 -> no grant, in_ready=0; reset asserted with out_valid=1 -> out_valid=0, out_data=0 next edge.
